// File: rtl/traffic_pkg.sv
// Shared encodings for the four-approach traffic scheduler: light codes,
// phase and direction enums, and the width of the phase timer.
package traffic_pkg;

  localparam int TIMER_W = 8;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  // Only the served approach ever leaves red, so a single decode covers all four lamps.
  function automatic logic [2:0] light_for(phase_e ph, logic [1:0] active, logic [1:0] me);
    if (ph == PH_GREEN && active == me)       return LIGHT_GREEN;
    else if (ph == PH_YELLOW && active == me) return LIGHT_YELLOW;
    else                                      return LIGHT_RED;
  endfunction

endpackage

// File: rtl/traffic_rr_arb.sv
// Combinational round-robin pick over the four approaches, starting at ptr
// and wrapping W -> N.
module traffic_rr_arb (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant = ptr + 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_sched.sv
// Four-approach traffic light scheduler: ALL_RED -> GREEN -> YELLOW cycle with
// round-robin service. Define TRAFFIC_EMERG_EN to compile in emergency preemption.
module traffic_sched
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [2:0] north_light,
  output logic [2:0] south_light,
  output logic [2:0] east_light,
  output logic [2:0] west_light,
  output logic [1:0] active_dir,
  output logic [1:0] phase
);

  localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] GMIN_LAST   = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_LAST   = TIMER_W'(GREEN_MAX - 1);

  phase_e             state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_inc;
  logic [1:0]         ptr;
  logic [1:0]         dir_q;
  logic [1:0]         arb_grant;
  logic               arb_valid;
  logic               e_act;
  logic [1:0]         e_dir;
  logic               others;
  logic               own;
  logic               go_yellow;

`ifdef TRAFFIC_EMERG_EN
  assign e_act = emerg_req;
  assign e_dir = emerg_dir;
`else
  logic unused_emerg;
  assign unused_emerg = ^{emerg_req, emerg_dir};
  assign e_act = 1'b0;
  assign e_dir = 2'd0;
`endif

  traffic_rr_arb u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  // Emergency for the served approach pins green; for any other it cuts green short.
  always_comb begin
    others = |(req & ~(4'b0001 << dir_q));
    own    = req[dir_q];
    if (e_act) go_yellow = (e_dir != dir_q);
    else       go_yellow = others && (timer >= GMAX_LAST || (timer >= GMIN_LAST && !own));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= PH_ALL_RED;
      timer <= '0;
      ptr   <= 2'd0;
      dir_q <= 2'd0;
    end else begin
      case (state)
        PH_ALL_RED: begin
          if (timer >= ALLRED_LAST && (e_act || arb_valid)) begin
            state <= PH_GREEN;
            timer <= '0;
            if (e_act) begin
              dir_q <= e_dir;
            end else begin
              dir_q <= arb_grant;
              ptr   <= arb_grant + 2'd1;
            end
          end else begin
            timer <= timer_inc;
          end
        end
        PH_GREEN: begin
          if (go_yellow) begin
            state <= PH_YELLOW;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        PH_YELLOW: begin
          if (timer >= YELLOW_LAST) begin
            state <= PH_ALL_RED;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        default: begin
          state <= PH_ALL_RED;
          timer <= '0;
        end
      endcase
    end
  end

  assign phase       = state;
  assign active_dir  = dir_q;
  assign north_light = light_for(state, dir_q, DIR_N);
  assign south_light = light_for(state, dir_q, DIR_S);
  assign east_light  = light_for(state, dir_q, DIR_E);
  assign west_light  = light_for(state, dir_q, DIR_W);

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench for traffic_sched: a cycle-count reference model queues the
// expected outputs after every edge and a monitor compares them one cycle at a time.
module tb_traffic_sched;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 3;
  localparam int ART  = 2;
`ifdef TRAFFIC_EMERG_EN
  localparam bit EMERG = 1'b1;
`else
  localparam bit EMERG = 1'b0;
`endif
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'd0;
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_dir = 2'd0;
  logic [2:0] north_light, south_light, east_light, west_light;
  logic [1:0] active_dir, phase;

  always #5 clock = ~clock;

  traffic_sched #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(ART)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .emerg_req   (emerg_req),
    .emerg_dir   (emerg_dir),
    .north_light (north_light),
    .south_light (south_light),
    .east_light  (east_light),
    .west_light  (west_light),
    .active_dir  (active_dir),
    .phase       (phase)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // Reference state: phase (0 all-red, 1 green, 2 yellow), cycles completed in it,
  // served approach and next round-robin start.
  int m_phase, m_cnt, m_dir, m_ptr;

  function automatic logic [15:0] dut_out();
    return {north_light, south_light, east_light, west_light, active_dir, phase};
  endfunction

  function automatic logic [15:0] expect_out();
    logic [2:0] l[4];
    for (int d = 0; d < 4; d++) begin
      if (m_phase == 1 && d == m_dir)      l[d] = GRN;
      else if (m_phase == 2 && d == m_dir) l[d] = YEL;
      else                                 l[d] = RED;
    end
    return {l[0], l[1], l[2], l[3], 2'(m_dir), 2'(m_phase)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%04h required=%04h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_dir   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  others, own, leave;
    nxt = m_cnt + 1;
    case (m_phase)
      0: begin
        if (nxt >= ART && ((EMERG && emerg_req) || req != 4'd0)) begin
          if (EMERG && emerg_req) begin
            m_dir = int'(emerg_dir);
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (req[(m_ptr + k) % 4]) begin
                m_dir = (m_ptr + k) % 4;
                break;
              end
            end
            m_ptr = (m_dir + 1) % 4;
          end
          m_phase = 1;
          m_cnt   = 0;
        end else m_cnt = nxt;
      end
      1: begin
        others = (req & ~(4'b0001 << m_dir)) != 4'd0;
        own    = req[m_dir];
        if (EMERG && emerg_req) leave = (int'(emerg_dir) != m_dir);
        else leave = others && (nxt >= GMAX || (nxt >= GMIN && !own));
        if (leave) begin
          m_phase = 2;
          m_cnt   = 0;
        end else m_cnt = nxt;
      end
      default: begin
        if (nxt >= YT) begin
          m_phase = 0;
          m_cnt   = 0;
        end else m_cnt = nxt;
      end
    endcase
  endtask

  // One clock: drive inputs, let the edge happen, queue what the model expects.
  task automatic cyc(input logic [3:0] r, input logic er, input logic [1:0] ed);
    req       = r;
    emerg_req = er;
    emerg_dir = ed;
    @(posedge clock);
    model_step();
    exp_q.push_back(expect_out());
    @(negedge clock);
  endtask

  // Asynchronous pulse between edges; outputs must already be at reset values.
  task automatic do_reset();
    #1 reset = 1'b0;
    #1 chk("reset_outputs", dut_out(), {RED, RED, RED, RED, 2'd0, 2'd0});
    #1 reset = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  always @(posedge clock) begin
    int nonred;
    #1;
    if (exp_q.size() > 0) chk("outputs", dut_out(), exp_q.pop_front());
    nonred = int'(north_light != RED) + int'(south_light != RED) +
             int'(east_light != RED) + int'(west_light != RED);
    chk("one_nonred", 16'(nonred <= 1), 16'd1);
  end

  initial begin
    int len, guard;
    logic [3:0] r;
    logic er;
    logic [1:0] ed;
    model_reset();

    // Single north demand: clearance, then green that never ends.
    do_reset();
    repeat (60) cyc(4'b0001, 1'b0, 2'd0);

    // Full contention: max-out rotation N,S,E,W,N.
    do_reset();
    repeat (80) cyc(4'b1111, 1'b0, 2'd0);

    // Gap-out: east arrives, north drops during green cycle 1.
    do_reset();
    repeat (3) cyc(4'b0001, 1'b0, 2'd0);
    repeat (20) cyc(4'b0100, 1'b0, 2'd0);

    // Emergency for west while north is green.
    do_reset();
    repeat (3) cyc(4'b0001, 1'b0, 2'd0);
    repeat (8) cyc(4'b0001, 1'b1, 2'd3);
    repeat (20) cyc(4'b0011, 1'b0, 2'd0);

    // Reset pulse mid-yellow, then contention again.
    do_reset();
    guard = 0;
    while (m_phase != 2 && guard < 40) begin
      cyc(4'b1111, 1'b0, 2'd0);
      guard++;
    end
    chk("reach_yellow", 16'(m_phase), 16'd2);
    cyc(4'b1111, 1'b0, 2'd0);
    do_reset();
    repeat (20) cyc(4'b1111, 1'b0, 2'd0);

    // Randomized held request patterns with occasional emergencies and resets.
    for (int s = 0; s < 150; s++) begin
      r   = 4'($urandom);
      len = $urandom_range(1, 20);
      er  = ($urandom_range(0, 9) == 0);
      ed  = 2'($urandom);
      if ($urandom_range(0, 24) == 0) do_reset();
      for (int k = 0; k < len; k++) cyc(r, er, ed);
    end

    @(posedge clock);
    #3;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sched.md
TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 4: minimum green cycles (1..255).
REQ-002 SHALL have parameter GREEN_MAX, default 10: maximum green cycles under contention (GREEN_MIN..255).
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow cycles (1..255).
REQ-004 SHALL have parameter ALLRED_T, default 2: all-red clearance cycles (1..255).
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, 4: vehicle demand per approach; bit0 N, bit1 S, bit2 E, bit3 W.
REQ-008 SHALL have port emerg_req, input, 1: emergency preemption request.
REQ-009 SHALL have port emerg_dir, input, 2: emergency approach (0 N, 1 S, 2 E, 3 W).
REQ-010 SHALL have ports north_light, south_light, east_light, west_light, output, 3 each: {red,yellow,green} one-hot (100 red, 010 yellow, 001 green).
REQ-011 SHALL have port active_dir, output, 2: approach currently or last served.
REQ-012 SHALL have port phase, output, 2: 0 ALL_RED, 1 GREEN, 2 YELLOW.

Function
REQ-013 SHALL implement a Moore FSM with states ALL_RED, GREEN, YELLOW and an 8-bit phase timer cleared on every state entry.
REQ-014 SHALL decode lights combinationally from state registers only: active_dir shows green/yellow in GREEN/YELLOW, all others red; every approach red in ALL_RED.
REQ-015 SHALL never show a non-red light on more than one approach in any cycle.
REQ-016 ALL_RED SHALL hold at least ALLRED_T cycles; at timer==ALLRED_T-1 or later, if any req bit set, SHALL grant the first requesting approach at or after pointer ptr (order N,S,E,W, wrap 3->0), enter GREEN, set active_dir to grant, set ptr to grant+1 mod 4.
REQ-017 ALL_RED with no request after clearance SHALL remain ALL_RED, re-evaluating every cycle; timer saturates.
REQ-018 GREEN SHALL go to YELLOW when another approach requests and either timer reached GREEN_MAX-1 (max-out) or timer >= GREEN_MIN-1 with own req bit low (gap-out).
REQ-019 GREEN with no other approach requesting SHALL persist indefinitely; timer saturates at 255.
REQ-020 YELLOW SHALL last exactly YELLOW_T cycles then enter ALL_RED.
REQ-021 Request bits SHALL be level-sensitive, sampled each cycle; no latching.

Reset
REQ-022 reset low SHALL immediately, without a clock edge, force state ALL_RED, timer 0, ptr 0, active_dir 0, phase 0, all four lights 100.
REQ-023 Reset asserted mid-GREEN/YELLOW SHALL abort the phase; after release, ALLRED_T clearance runs before any green.

Configuration
REQ-024 Macro TRAFFIC_EMERG_EN SHALL compile in emergency preemption; ports emerg_req/emerg_dir SHALL exist in both builds.
REQ-025 With TRAFFIC_EMERG_EN: emerg_req in GREEN with active_dir!=emerg_dir SHALL enter YELLOW next edge, ignoring GREEN_MIN.
REQ-026 With TRAFFIC_EMERG_EN: GREEN with active_dir==emerg_dir SHALL hold green while emerg_req high, ignoring max-out.
REQ-027 With TRAFFIC_EMERG_EN: ALL_RED clearance end with emerg_req high SHALL grant emerg_dir regardless of req; ptr unchanged.
REQ-028 Without TRAFFIC_EMERG_EN: emerg_req/emerg_dir SHALL be ignored entirely.

Structure
REQ-029 Package traffic_pkg SHALL hold light encodings, phase state enum, direction enum (N,S,E,W) and timer width constant.
REQ-030 Round-robin selection SHALL be a sub-module traffic_rr_arb (req[3:0], ptr[1:0] in; grant[1:0], valid out), purely combinational.

Verification (GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2)
REQ-031 Release reset, req=0001 held -> 2 all-red cycles, north 001 from cycle 3, holds green 50+ cycles.
REQ-032 req=1111 held -> greens N,S,E,W,N in order, each 10 green + 3 yellow + 2 all-red = 15-cycle period.
REQ-033 N green, req=0100 (N low) at green cycle 1 -> N yellow after green cycle 4, E green after 3 yellow + 2 all-red.
REQ-034 EMERG_EN build, N green cycle 1, emerg_req=1, emerg_dir=3 -> N yellow next edge, W green after 3+2 cycles, ptr unchanged; non-EMERG build -> no effect.
REQ-035 Async reset pulsed mid-yellow between clock edges -> all lights 100 before next edge; no green within 2 cycles of release.
REQ-036 Every cycle of all scenarios -> assertion: at most one light not 100.
